// File: rtl/led_p2s_shifter.sv
// LED parallel-to-serial shifter.
// Captures a parallel frame on a one-cycle load pulse and shifts it out
// MSB-first on an s_clk/s_data pair for 74HC595-class chips. It then holds
// s_latch high for DIV cycles and pulses done once the frame is complete.
module led_p2s_shifter #(
  parameter int WIDTH = 17,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  output logic             s_clk,
  output logic             s_data,
  output logic             s_latch,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_e;

  // One spare bit on each counter so that neither can wrap within a frame.
  localparam int BCW = $clog2(WIDTH) + 1;
  localparam int DCW = $clog2(DIV) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(DIV - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [BCW-1:0]   bit_cnt_q;
  logic [DCW-1:0]   div_cnt_q;
  logic             s_clk_q;
  logic             s_latch_q;
  logic             busy_q;
  logic             done_q;
  logic             div_last;

  // The last cycle of any DIV-long phase.
  assign div_last = (div_cnt_q == LAST_DIV);

  // Shift the next bit into the MSB position, filling with zero.
  assign sreg_d = {sreg_q[WIDTH-2:0], 1'b0};

  // Frame sequencer. Registered outputs are updated together with the state,
  // so each output lines up with the state it belongs to.
  // NOTE: state is written with <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      s_clk_q   <= 1'b0;
      s_latch_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            sreg_q    <= par_in;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_last) begin
            div_cnt_q <= '0;
            s_clk_q   <= 1'b1;
            state_q   <= SHIFT_HI;
          end else begin
            div_cnt_q <= div_cnt_q + DCW'(1);
          end
        end
        SHIFT_HI: begin
          if (div_last) begin
            div_cnt_q <= '0;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            s_clk_q   <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              s_latch_q <= 1'b1;
              state_q   <= LATCH;
            end else begin
              state_q   <= SHIFT_LO;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DCW'(1);
          end
        end
        LATCH: begin
          if (div_last) begin
            div_cnt_q <= '0;
            s_latch_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            div_cnt_q <= div_cnt_q + DCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // s_data follows the shift register MSB and is held low outside the shift states.
  assign s_data  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) & sreg_q[WIDTH-1];
  assign s_clk   = s_clk_q;
  assign s_latch = s_latch_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_led_p2s_shifter.sv
// Bench for led_p2s_shifter: a DIV=4 and a DIV=1 instance share the stimulus.
// A frame-offset model predicts every output on every cycle.
module tb_led_p2s_shifter;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] par_in = '0;

  logic [1:0] s_clk_w, s_data_w, s_latch_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_p2s_shifter #(.WIDTH(W), .DIV(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .par_in(par_in),
    .s_clk(s_clk_w[0]), .s_data(s_data_w[0]), .s_latch(s_latch_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  led_p2s_shifter #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .par_in(par_in),
    .s_clk(s_clk_w[1]), .s_data(s_data_w[1]), .s_latch(s_latch_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // ---------------- behavioural model ----------------
  // A frame is WIDTH bit slots of 2*DIV cycles (low half, then high half),
  // followed by DIV latch cycles. The model tracks the cycle offset into the
  // frame and derives all outputs from that offset arithmetically.
  bit           m_active [2] = '{1'b0, 1'b0};
  int           m_off    [2] = '{0, 0};
  logic [W-1:0] m_word   [2];
  bit           m_done   [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
      end else if (m_active[i]) begin
        m_off[i]++;
        if (m_off[i] == W * 2 * dv(i) + dv(i)) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (load) begin
          m_active[i] = 1'b1;
          m_off[i]    = 0;
          m_word[i]   = par_in;
        end
      end
    end
  end

  // Returns {s_clk, s_data, s_latch, busy, done}.
  function automatic logic [4:0] model_out(input int i);
    int b;
    logic [4:0] r;
    r = {4'b0000, m_done[i]};
    if (m_active[i]) begin
      b = m_off[i] / (2 * dv(i));
      r[1] = 1'b1;
      if (b < W) begin
        r[4] = ((m_off[i] % (2 * dv(i))) >= dv(i));
        r[3] = m_word[i][W-1-b];
      end else begin
        r[2] = 1'b1;
      end
    end
    return r;
  endfunction

  // Per-cycle compare, 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0] e;
        e = model_out(i);
        check($sformatf("d%0d_s_clk", i),   s_clk_w[i],   e[4]);
        check($sformatf("d%0d_s_data", i),  s_data_w[i],  e[3]);
        check($sformatf("d%0d_s_latch", i), s_latch_w[i], e[2]);
        check($sformatf("d%0d_busy", i),    busy_w[i],    e[1]);
        check($sformatf("d%0d_done", i),    done_w[i],    e[0]);
      end
    end
  end

  // ---------------- frame statistics for literal checks ----------------
  int           rises   [2];
  int           busy_c  [2];
  int           latch_c [2];
  int           done_c  [2];
  logic [W-1:0] cap     [2];
  logic         prev_clk [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_clk_w[i] === 1'b1 && prev_clk[i] === 1'b0) begin
        rises[i]++;
        cap[i] = {cap[i][W-2:0], s_data_w[i]};
      end
      prev_clk[i] = s_clk_w[i];
      if (busy_w[i] === 1'b1)    busy_c[i]++;
      if (s_latch_w[i] === 1'b1) latch_c[i]++;
      if (done_w[i] === 1'b1)    done_c[i]++;
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; busy_c[i] = 0; latch_c[i] = 0; done_c[i] = 0; cap[i] = '0;
    end
  endtask

  task automatic pulse(input logic [W-1:0] w);
    par_in = w;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) found = 1'b1;
    end
    check("wait_done0", found, 1);
  endtask

  task automatic check_frame(input int i, input logic [W-1:0] word, input int busy_len);
    check($sformatf("d%0d_rises", i),  rises[i],   W);
    check($sformatf("d%0d_bits", i),   cap[i],     word);
    check($sformatf("d%0d_busylen", i), busy_c[i], busy_len);
    check($sformatf("d%0d_latchlen", i), latch_c[i], dv(i));
    check($sformatf("d%0d_dones", i),  done_c[i],  1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset for 3 cycles.
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy",  busy_w,    2'b00);
    check("reset_s_clk", s_clk_w,   2'b00);
    check("reset_latch", s_latch_w, 2'b00);
    check("reset_data",  s_data_w,  2'b00);
    check("reset_done",  done_w,    2'b00);

    // Single frame with the reference word.
    clear_stats();
    pulse(17'h1_A5C3);
    repeat (150) @(negedge clk);
    check("frame1_bits_lit", cap[0], 17'b1_1010_0101_1100_0011);
    check_frame(0, 17'h1_A5C3, 140);
    check_frame(1, 17'h1_A5C3, 35);

    // Boundary words.
    clear_stats();
    pulse(17'h0_0000);
    repeat (150) @(negedge clk);
    check_frame(0, 17'h0_0000, 140);
    clear_stats();
    pulse(17'h1_FFFF);
    repeat (150) @(negedge clk);
    check_frame(0, 17'h1_FFFF, 140);

    // Load while busy: second load 20 cycles in is ignored.
    clear_stats();
    pulse(17'h1_5A3C);
    repeat (19) @(negedge clk);
    pulse(17'h0_FFFF);
    repeat (150) @(negedge clk);
    check_frame(0, 17'h1_5A3C, 140);
    check_frame(1, 17'h1_5A3C, 35);

    // Back-to-back: load in the done cycle.
    clear_stats();
    pulse(17'h1_A5C3);
    wait_done0(200);
    pulse(17'h0_0001);
    repeat (150) @(negedge clk);
    check("b2b_dones",  done_c[0], 2);
    check("b2b_busy",   busy_c[0], 280);
    check("b2b_rises",  rises[0],  34);
    check("b2b_bits",   cap[0],    17'h0_0001);
    check("b2b_d1_dones", done_c[1], 2);

    // Reset mid-frame, during the high half of bit 8 on the DIV=4 instance.
    clear_stats();
    pulse(17'h1_FFFF);
    repeat (69) @(negedge clk);
    check("pre_rst_s_clk", s_clk_w[0], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_s_clk", s_clk_w[0],   1'b0);
    check("abort_data",  s_data_w[0],  1'b0);
    check("abort_latch", s_latch_w[0], 1'b0);
    check("abort_busy",  busy_w[0],    1'b0);
    repeat (20) @(negedge clk);
    check("abort_no_done",  done_c[0],  0);
    check("abort_no_latch", latch_c[0], 0);
    clear_stats();
    pulse(17'h1_3C5A);
    repeat (150) @(negedge clk);
    check_frame(0, 17'h1_3C5A, 140);

    // DIV=1 focus word: data high at first and last rise only.
    clear_stats();
    pulse(17'h1_0001);
    repeat (150) @(negedge clk);
    check_frame(1, 17'h1_0001, 35);
    check_frame(0, 17'h1_0001, 140);

    // Randomized traffic: random loads, words and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      load   = ($urandom_range(0, 9) == 0);
      par_in = W'($urandom);
      rst_n  = ($urandom_range(0, 799) != 0);
      @(negedge clk);
    end
    load  = 1'b0;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
